// File: rtl/bwt_occ_responder.sv
// Occurrence-lookup responder: issues a k-line then l-line read per lookup,
// pairs the in-order returns and queues results behind a credit limit.
module bwt_occ_responder #(
  parameter int ADDR_W = 42,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              request_valid_i,
  output logic              request_ready_o,
  input  logic [8:0]        read_num_i,
  input  logic [ADDR_W-1:0] addr_k_i,
  input  logic [ADDR_W-1:0] addr_l_i,
  output logic              mem_req_valid_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  input  logic              mem_req_ready_i,
  input  logic              mem_rsp_valid_i,
  input  logic [383:0]      mem_rsp_data_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [8:0]        resp_read_num_o,
  output logic [31:0]       cnt_a0_o,
  output logic [31:0]       cnt_a1_o,
  output logic [31:0]       cnt_a2_o,
  output logic [31:0]       cnt_a3_o,
  output logic [63:0]       cnt_b0_o,
  output logic [63:0]       cnt_b1_o,
  output logic [63:0]       cnt_b2_o,
  output logic [63:0]       cnt_b3_o,
  output logic [31:0]       cntl_a0_o,
  output logic [31:0]       cntl_a1_o,
  output logic [31:0]       cntl_a2_o,
  output logic [31:0]       cntl_a3_o,
  output logic [63:0]       cntl_b0_o,
  output logic [63:0]       cntl_b1_o,
  output logic [63:0]       cntl_b2_o,
  output logic [63:0]       cntl_b3_o,
  output logic              rsp_error_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE_K, ISSUE_L} state_e;

  state_e              state_q;
  logic                mem_req_valid_q;
  logic [ADDR_W-1:0]   mem_req_addr_q;

  logic [8:0]          req_num_mem [DEPTH];
  logic [ADDR_W-1:0]   req_k_mem   [DEPTH];
  logic [ADDR_W-1:0]   req_l_mem   [DEPTH];
  logic [PW-1:0]       req_wr_q, req_rd_q, req_nx;
  logic [CW-1:0]       req_cnt_q, req_cnt_d;
  logic                request_ready_q;

  logic [8:0]          tag_mem [DEPTH];
  logic [PW-1:0]       tag_wr_q, tag_rd_q;

  logic [8:0]          rsp_num_mem [DEPTH];
  logic [383:0]        rsp_k_mem   [DEPTH];
  logic [383:0]        rsp_l_mem   [DEPTH];
  logic [PW-1:0]       rsp_wr_q, rsp_rd_q;
  logic [CW-1:0]       rsp_cnt_q, rsp_cnt_d;

  logic [CW-1:0]       in_flight_q, in_flight_d;
  logic                half_q, rsp_error_q;
  logic [383:0]        k_line_q;

  logic req_push, req_pop, credit_ok, start_k, chain_k, reserve;
  logic pair_done, spurious, rsp_pop;
  logic [383:0] head_k, head_l;

  always_comb begin
    req_push    = request_valid_i & request_ready_q;
    req_nx      = req_rd_q + 1'b1;
    // Conservative: a release landing this cycle is only seen next cycle.
    credit_ok   = ({1'b0, in_flight_q} + {1'b0, rsp_cnt_q}) < {1'b0, DEPTH_C};
    start_k     = (state_q == IDLE) && (req_cnt_q != '0) && credit_ok;
    req_pop     = (state_q == ISSUE_L) && mem_req_ready_i;
    chain_k     = req_pop && (req_cnt_q > CW'(1)) && credit_ok;
    reserve     = start_k | chain_k;
    req_cnt_d   = req_cnt_q + CW'(req_push) - CW'(req_pop);
    pair_done   = mem_rsp_valid_i & half_q;
    spurious    = mem_rsp_valid_i & ~half_q & (in_flight_q == '0);
    in_flight_d = in_flight_q + CW'(reserve) - CW'(pair_done);
    rsp_pop     = resp_valid_o & resp_ready_i;
    rsp_cnt_d   = rsp_cnt_q + CW'(pair_done) - CW'(rsp_pop);
  end

  // NOTE: FIFO storage carries no reset; pointers and counts alone define validity.
  always_ff @(posedge clk_i) begin
    if (req_push) begin
      req_num_mem[req_wr_q] <= read_num_i;
      req_k_mem[req_wr_q]   <= addr_k_i;
      req_l_mem[req_wr_q]   <= addr_l_i;
    end
    if (req_pop) tag_mem[tag_wr_q] <= req_num_mem[req_rd_q];
    if (mem_rsp_valid_i && !half_q) k_line_q <= mem_rsp_data_i;
    if (pair_done) begin
      rsp_num_mem[rsp_wr_q] <= tag_mem[tag_rd_q];
      rsp_k_mem[rsp_wr_q]   <= k_line_q;
      rsp_l_mem[rsp_wr_q]   <= mem_rsp_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req_wr_q        <= '0;
      req_rd_q        <= '0;
      req_cnt_q       <= '0;
      request_ready_q <= 1'b0;
      tag_wr_q        <= '0;
      tag_rd_q        <= '0;
      rsp_wr_q        <= '0;
      rsp_rd_q        <= '0;
      rsp_cnt_q       <= '0;
      in_flight_q     <= '0;
      half_q          <= 1'b0;
      rsp_error_q     <= 1'b0;
    end else begin
      if (req_push) req_wr_q <= req_wr_q + 1'b1;
      if (req_pop) begin
        req_rd_q <= req_nx;
        tag_wr_q <= tag_wr_q + 1'b1;
      end
      req_cnt_q       <= req_cnt_d;
      request_ready_q <= (req_cnt_d < DEPTH_C);
      if (pair_done) begin
        tag_rd_q <= tag_rd_q + 1'b1;
        rsp_wr_q <= rsp_wr_q + 1'b1;
      end
      if (rsp_pop) rsp_rd_q <= rsp_rd_q + 1'b1;
      rsp_cnt_q   <= rsp_cnt_d;
      in_flight_q <= in_flight_d;
      if (pair_done) half_q <= 1'b0;
      else if (mem_rsp_valid_i && !spurious) half_q <= 1'b1;
      if (spurious) rsp_error_q <= 1'b1;
    end
  end

  // Issue FSM with registered request outputs; they hold while memory stalls.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_k) begin
          state_q         <= ISSUE_K;
          mem_req_valid_q <= 1'b1;
          mem_req_addr_q  <= req_k_mem[req_rd_q];
        end
        ISSUE_K: if (mem_req_ready_i) begin
          state_q        <= ISSUE_L;
          mem_req_addr_q <= req_l_mem[req_rd_q];
        end
        ISSUE_L: if (mem_req_ready_i) begin
          if (chain_k) begin
            state_q        <= ISSUE_K;
            mem_req_addr_q <= req_k_mem[req_nx];
          end else begin
            state_q         <= IDLE;
            mem_req_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q         <= IDLE;
          mem_req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Result fields read as zero while the response FIFO is empty.
  assign resp_valid_o    = (rsp_cnt_q != '0);
  assign head_k          = resp_valid_o ? rsp_k_mem[rsp_rd_q] : '0;
  assign head_l          = resp_valid_o ? rsp_l_mem[rsp_rd_q] : '0;
  assign resp_read_num_o = resp_valid_o ? rsp_num_mem[rsp_rd_q] : '0;

  assign cnt_a0_o  = head_k[31:0];
  assign cnt_a1_o  = head_k[63:32];
  assign cnt_a2_o  = head_k[95:64];
  assign cnt_a3_o  = head_k[127:96];
  assign cnt_b0_o  = head_k[191:128];
  assign cnt_b1_o  = head_k[255:192];
  assign cnt_b2_o  = head_k[319:256];
  assign cnt_b3_o  = head_k[383:320];
  assign cntl_a0_o = head_l[31:0];
  assign cntl_a1_o = head_l[63:32];
  assign cntl_a2_o = head_l[95:64];
  assign cntl_a3_o = head_l[127:96];
  assign cntl_b0_o = head_l[191:128];
  assign cntl_b1_o = head_l[255:192];
  assign cntl_b2_o = head_l[319:256];
  assign cntl_b3_o = head_l[383:320];

  assign request_ready_o = request_ready_q;
  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_req_addr_o  = mem_req_addr_q;
  assign rsp_error_o     = rsp_error_q;

endmodule

// File: tb/tb_bwt_occ_responder.sv
// Bench for bwt_occ_responder: directed vectors, corner sequences and a
// randomized run against an in-order lookup scoreboard and memory model.
module tb_bwt_occ_responder;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic request_valid_i, request_ready_o;
  logic [8:0] read_num_i;
  logic [41:0] addr_k_i, addr_l_i;
  logic mem_req_valid_o, mem_req_ready_i;
  logic [41:0] mem_req_addr_o;
  logic mem_rsp_valid_i;
  logic [383:0] mem_rsp_data_i;
  logic resp_valid_o, resp_ready_i;
  logic [8:0] resp_read_num_o;
  logic [31:0] cnt_a0_o, cnt_a1_o, cnt_a2_o, cnt_a3_o;
  logic [63:0] cnt_b0_o, cnt_b1_o, cnt_b2_o, cnt_b3_o;
  logic [31:0] cntl_a0_o, cntl_a1_o, cntl_a2_o, cntl_a3_o;
  logic [63:0] cntl_b0_o, cntl_b1_o, cntl_b2_o, cntl_b3_o;
  logic rsp_error_o;

  bwt_occ_responder #(.ADDR_W(42), .DEPTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .request_valid_i(request_valid_i), .request_ready_o(request_ready_o),
    .read_num_i(read_num_i), .addr_k_i(addr_k_i), .addr_l_i(addr_l_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_ready_i(mem_req_ready_i),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_read_num_o(resp_read_num_o),
    .cnt_a0_o(cnt_a0_o), .cnt_a1_o(cnt_a1_o), .cnt_a2_o(cnt_a2_o), .cnt_a3_o(cnt_a3_o),
    .cnt_b0_o(cnt_b0_o), .cnt_b1_o(cnt_b1_o), .cnt_b2_o(cnt_b2_o), .cnt_b3_o(cnt_b3_o),
    .cntl_a0_o(cntl_a0_o), .cntl_a1_o(cntl_a1_o), .cntl_a2_o(cntl_a2_o), .cntl_a3_o(cntl_a3_o),
    .cntl_b0_o(cntl_b0_o), .cntl_b1_o(cntl_b1_o), .cntl_b2_o(cntl_b2_o), .cntl_b3_o(cntl_b3_o),
    .rsp_error_o(rsp_error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [8:0]  tag;
    logic [41:0] k;
    logic [41:0] l;
    logic [31:0] exp_a0;
    logic [63:0] exp_b0;
    logic [63:0] exp_lb3;
  } vec_t;

  typedef struct {
    logic [8:0]  tag;
    logic [41:0] k;
    logic [41:0] l;
  } lk_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rsp_cyc = 0;
  int last_due = 0;
  int mr_mode = 0;   // 0 always ready, 1 random, 2 stalled
  int rr_mode = 1;   // 0 always ready, 1 stalled, 2 random
  int lat_min = 3;
  int lat_max = 3;
  logic stray = 1'b0;

  lk_t         exp_rsp[$];
  logic [41:0] exp_req[$];
  logic [41:0] req_log[$];
  int          req_cyc[$];
  int          due_q[$];
  logic [41:0] addr_q[$];
  lk_t         e;

  // Memory content: every field encodes its index and the line address.
  function automatic logic [383:0] line(input logic [41:0] a);
    logic [383:0] r;
    for (int i = 0; i < 4; i++) begin
      r[32*i +: 32]      = {4'(i), a[27:0]};
      r[128+64*i +: 64]  = {4'(i + 4), 18'h0, a};
    end
    return r;
  endfunction

  function automatic logic [41:0] rnd_addr();
    return 42'({$urandom(), $urandom()});
  endfunction

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: in-order returns with per-request latency.
  initial begin
    int d;
    mem_req_ready_i = 1'b1;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
    forever begin
      @(posedge clk_i); #2;
      cyc++;
      mem_req_ready_i = (mr_mode == 0) ? 1'b1 : (mr_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      if (stray) begin
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = '1;
        stray = 1'b0;
      end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = line(addr_q.pop_front());
        void'(due_q.pop_front());
        last_rsp_cyc = cyc;
      end else begin
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
      end
      @(negedge clk_i);
      if (rst_ni && mem_req_valid_o && mem_req_ready_i) begin
        d = cyc + $urandom_range(lat_min, lat_max);
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        due_q.push_back(d);
        addr_q.push_back(mem_req_addr_o);
        req_log.push_back(mem_req_addr_o);
        req_cyc.push_back(cyc);
        if (exp_req.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_req_unexpected: got %0h expected none", mem_req_addr_o);
        end else begin
          check("mem_req_addr", mem_req_addr_o, exp_req.pop_front());
        end
      end
    end
  end

  initial begin
    resp_ready_i = 1'b0;
    forever begin
      @(posedge clk_i); #2;
      resp_ready_i = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // Reference model: accepted lookups become k,l reads and then results, in order.
  always @(negedge clk_i) begin
    if (rst_ni && request_valid_i && request_ready_o) begin
      exp_rsp.push_back('{read_num_i, addr_k_i, addr_l_i});
      exp_req.push_back(addr_k_i);
      exp_req.push_back(addr_l_i);
    end
    if (rst_ni && resp_valid_o && resp_ready_i) begin
      if (exp_rsp.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp_unexpected: got tag %0d expected none", resp_read_num_o);
      end else begin
        e = exp_rsp.pop_front();
        check("resp_tag", resp_read_num_o, e.tag);
        check("resp_k_line", {cnt_b3_o, cnt_b2_o, cnt_b1_o, cnt_b0_o,
                              cnt_a3_o, cnt_a2_o, cnt_a1_o, cnt_a0_o}, line(e.k));
        check("resp_l_line", {cntl_b3_o, cntl_b2_o, cntl_b1_o, cntl_b0_o,
                              cntl_a3_o, cntl_a2_o, cntl_a1_o, cntl_a0_o}, line(e.l));
      end
    end
  end

  task automatic send(input logic [8:0] t, input logic [41:0] k, input logic [41:0] l);
    int n = 0;
    request_valid_i = 1'b1;
    read_num_i = t;
    addr_k_i   = k;
    addr_l_i   = l;
    @(negedge clk_i);
    while (!request_ready_o && n < 300) begin
      n++;
      @(negedge clk_i);
    end
    if (n >= 300) check("send_timeout", 1'b0, 1'b1);
    @(posedge clk_i); #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_rsp.size() != 0 || exp_req.size() != 0) && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    check("drain_left", exp_rsp.size(), 0);
    @(posedge clk_i); #1;
  endtask

  task automatic flush();
    exp_rsp.delete();
    exp_req.delete();
    due_q.delete();
    addr_q.delete();
    last_due = 0;
  endtask

  task automatic wait_resp(input string name);
    int n = 0;
    @(negedge clk_i);
    while (!resp_valid_o && n < 200) begin
      n++;
      @(negedge clk_i);
    end
    check(name, resp_valid_o, 1'b1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[3];
    logic [41:0] rk[4];
    logic [41:0] rl[4];
    int n;

    vecs[0] = '{9'd5,   42'h100,         42'h200,         32'h0000_0100, 64'h4000_0000_0000_0100, 64'h7000_0000_0000_0200};
    vecs[1] = '{9'h1FF, 42'h3FF_FFFF_FFFF, 42'h0,           32'h0FFF_FFFF, 64'h4000_03FF_FFFF_FFFF, 64'h7000_0000_0000_0000};
    vecs[2] = '{9'd0,   42'h2AA_AAAA_AAAA, 42'h155_5555_5555, 32'h0AAA_AAAA, 64'h4000_02AA_AAAA_AAAA, 64'h7000_0155_5555_5555};

    rst_ni = 1'b0;
    request_valid_i = 1'b0;
    read_num_i = '0;
    addr_k_i = '0;
    addr_l_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_request_ready", request_ready_o, 1'b0);
    check("rst_mem_req_valid", mem_req_valid_o, 1'b0);
    check("rst_mem_req_addr", mem_req_addr_o, 42'h0);
    check("rst_resp_valid", resp_valid_o, 1'b0);
    check("rst_resp_tag", resp_read_num_o, 9'h0);
    check("rst_rsp_error", rsp_error_o, 1'b0);
    check("rst_cnt_all", {cnt_b3_o, cnt_b2_o, cnt_b1_o, cnt_b0_o, cnt_a3_o, cnt_a2_o, cnt_a1_o, cnt_a0_o}
                         | {cntl_b3_o, cntl_b2_o, cntl_b1_o, cntl_b0_o, cntl_a3_o, cntl_a2_o, cntl_a1_o, cntl_a0_o}, '0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("ready_after_reset", request_ready_o, 1'b1);
    @(posedge clk_i); #1;

    // Directed lookups, results held until inspected.
    for (int i = 0; i < 3; i++) begin
      req_log.delete();
      req_cyc.delete();
      send(vecs[i].tag, vecs[i].k, vecs[i].l);
      request_valid_i = 1'b0;
      wait_resp("vec_resp_valid");
      check("vec_latency", cyc, last_rsp_cyc + 1);
      check("vec_tag", resp_read_num_o, vecs[i].tag);
      check("vec_cnt_a0", cnt_a0_o, vecs[i].exp_a0);
      check("vec_cnt_b0", cnt_b0_o, vecs[i].exp_b0);
      check("vec_cntl_b3", cntl_b3_o, vecs[i].exp_lb3);
      if (i == 0) begin
        check("vec_req_count", req_log.size(), 2);
        if (req_log.size() >= 2) begin
          check("vec_req_k", req_log[0], vecs[i].k);
          check("vec_req_l", req_log[1], vecs[i].l);
          check("vec_req_consecutive", req_cyc[1], req_cyc[0] + 1);
        end
      end
      @(posedge clk_i); #1;
      rr_mode = 0;
      @(posedge clk_i); #1;
      rr_mode = 1;
    end
    drain();

    // Memory stall during ISSUE_K while the request FIFO fills.
    req_log.delete();
    mr_mode = 2;
    for (int i = 0; i < 4; i++) begin
      rk[i] = rnd_addr();
      rl[i] = rnd_addr();
      send(9'(30 + i), rk[i], rl[i]);
    end
    request_valid_i = 1'b0;
    repeat (4) begin
      @(negedge clk_i);
      check("full_request_ready", request_ready_o, 1'b0);
      check("stall_req_valid", mem_req_valid_o, 1'b1);
      check("stall_req_addr", mem_req_addr_o, rk[0]);
      check("stall_no_l_early", req_log.size(), 0);
    end
    @(posedge clk_i); #1;
    mr_mode = 0;
    wait_resp("bp_resp_valid");
    check("bp_first_k", req_log[0], rk[0]);
    check("bp_first_l", req_log[1], rl[0]);
    repeat (10) begin
      @(negedge clk_i);
      check("hold_valid", resp_valid_o, 1'b1);
      check("hold_tag", resp_read_num_o, 9'd30);
      check("hold_cnt_a0", cnt_a0_o, line(rk[0])[31:0]);
      check("hold_cntl_b3", cntl_b3_o, line(rl[0])[383:320]);
    end
    @(posedge clk_i); #1;
    rr_mode = 2;
    drain();

    // Credit stall: six lookups, results not consumed.
    req_log.delete();
    rr_mode = 1;
    for (int i = 0; i < 6; i++) send(9'(40 + i), rnd_addr(), rnd_addr());
    request_valid_i = 1'b0;
    repeat (40) @(negedge clk_i);
    check("credit_req_count", req_log.size(), 8);
    check("credit_fsm_idle", mem_req_valid_o, 1'b0);
    check("credit_resp_valid", resp_valid_o, 1'b1);
    @(posedge clk_i); #1;
    rr_mode = 0;
    drain();
    check("credit_req_total", req_log.size(), 12);

    // Back-to-back tags 1..8, then randomized traffic with random stalls.
    mr_mode = 1;
    rr_mode = 2;
    lat_min = 1;
    lat_max = 6;
    for (int t = 1; t <= 8; t++) send(9'(t), rnd_addr(), rnd_addr());
    request_valid_i = 1'b0;
    drain();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        request_valid_i = 1'b0;
        @(posedge clk_i); #1;
      end
      send(9'($urandom), rnd_addr(), rnd_addr());
    end
    request_valid_i = 1'b0;
    drain();

    // Reset with two pairs outstanding, then a stray return.
    mr_mode = 0;
    rr_mode = 0;
    lat_min = 20;
    lat_max = 20;
    req_log.delete();
    send(9'd70, rnd_addr(), rnd_addr());
    send(9'd71, rnd_addr(), rnd_addr());
    request_valid_i = 1'b0;
    n = 0;
    while (req_log.size() < 4 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("midrst_pairs_issued", req_log.size(), 4);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    flush();
    @(posedge clk_i);
    @(negedge clk_i);
    check("midrst_request_ready", request_ready_o, 1'b0);
    check("midrst_mem_req_valid", mem_req_valid_o, 1'b0);
    check("midrst_mem_req_addr", mem_req_addr_o, 42'h0);
    check("midrst_resp_valid", resp_valid_o, 1'b0);
    check("midrst_rsp_error", rsp_error_o, 1'b0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    stray = 1'b1;
    @(negedge clk_i);
    check("stray_before", rsp_error_o, 1'b0);
    repeat (3) begin
      @(negedge clk_i);
      check("stray_error_sticky", rsp_error_o, 1'b1);
      check("stray_no_resp", resp_valid_o, 1'b0);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    check("error_cleared_by_reset", rsp_error_o, 1'b0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
